// File: rtl/vm_param.sv
// Parametrised vending-machine controller: multi-coin credit, per-product stock,
// greedy one-coin-per-cycle change, cancel, inactivity timeout and restocking.
module vm_param #(
   parameter int PRICE      = 10,
   parameter int MAX_CREDIT = 40,
   parameter int CREDIT_W   = 6,
   parameter int N_PROD     = 4,
   parameter int ID_W       = 2,
   parameter int STOCK_MAX  = 9,
   parameter int STOCK_W    = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          cash_in,
   input  logic                sel_valid,
   input  logic [ID_W-1:0]     sel_id,
   input  logic                cancel,
   input  logic                restock,
   input  logic [ID_W-1:0]     restock_id,
   output logic                purchase,
   output logic [ID_W-1:0]     vend_id,
   output logic [1:0]          cash_return,
   output logic                coin_reject,
   output logic                sold_out,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          present_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COLLECT = 2'b01,
      CHANGE  = 2'b10
   } state_t;

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(10);
   localparam logic [CREDIT_W-1:0] C20     = CREDIT_W'(20);
   localparam logic [ID_W:0]       N_PROD_C   = (ID_W + 1)'(N_PROD);
   localparam logic [TMR_W-1:0]    TIMEOUT_C  = TMR_W'(TIMEOUT);
   localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(STOCK_MAX);

   state_t               state, state_next;
   logic [CREDIT_W-1:0]  credit_next;
   logic [TMR_W-1:0]     timer, timer_next;
   logic                 purchase_next, coin_reject_next, sold_out_next;
   logic [ID_W-1:0]      vend_id_next;
   logic [1:0]           cash_return_next;
   logic [STOCK_W-1:0]   stock [N_PROD];
   logic                 dec_en, restock_en;
   logic [CREDIT_W-1:0]  coin_val, change_val;
   logic                 coin_present, coin_ok, sel_in_range, restock_in_range;

   always_comb begin
      case (cash_in)
         2'b01:   coin_val = C5;
         2'b10:   coin_val = C10;
         2'b11:   coin_val = C20;
         default: coin_val = '0;
      endcase
   end

   // A coin is credited only when nothing with higher priority claims the cycle.
   assign coin_present     = (cash_in != 2'b00);
   assign coin_ok          = coin_present && (state == IDLE || state == COLLECT) &&
                             !sel_valid && !cancel && ((credit + coin_val) <= MAX_C);
   assign sel_in_range     = ({1'b0, sel_id} < N_PROD_C);
   assign restock_in_range = ({1'b0, restock_id} < N_PROD_C);

   always_comb begin
      state_next       = state;
      credit_next      = credit;
      timer_next       = timer;
      purchase_next    = 1'b0;
      vend_id_next     = vend_id;
      cash_return_next = 2'b00;
      coin_reject_next = coin_present && !coin_ok;
      sold_out_next    = 1'b0;
      dec_en           = 1'b0;
      restock_en       = 1'b0;
      change_val       = '0;
      case (state)
         IDLE: begin
            restock_en = restock && restock_in_range;
            if (coin_ok) begin
               credit_next = credit + coin_val;
               state_next  = COLLECT;
               timer_next  = '0;
            end
         end
         COLLECT: begin
            if (cancel) begin
               state_next = CHANGE;
               timer_next = '0;
            end else if (sel_valid) begin
               timer_next = '0;
               if (!sel_in_range) begin
                  state_next = COLLECT;
               end else if (stock[sel_id] == '0) begin
                  sold_out_next = 1'b1;
               end else if (credit >= PRICE_C) begin
                  purchase_next = 1'b1;
                  vend_id_next  = sel_id;
                  dec_en        = 1'b1;
                  credit_next   = credit - PRICE_C;
                  state_next    = (credit == PRICE_C) ? IDLE : CHANGE;
               end
            end else if (coin_ok) begin
               credit_next = credit + coin_val;
               timer_next  = '0;
            end else begin
               timer_next = timer + TMR_W'(1);
               if (timer_next == TIMEOUT_C) begin
                  state_next = CHANGE;
                  timer_next = '0;
               end
            end
         end
         CHANGE: begin
            // Greedy: largest coin not exceeding the remaining credit.
            if (credit >= C20) begin
               change_val       = C20;
               cash_return_next = 2'b11;
            end else if (credit >= C10) begin
               change_val       = C10;
               cash_return_next = 2'b10;
            end else if (credit != '0) begin
               change_val       = C5;
               cash_return_next = 2'b01;
            end
            credit_next = credit - change_val;
            if (credit_next == '0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         credit      <= '0;
         timer       <= '0;
         purchase    <= 1'b0;
         vend_id     <= '0;
         cash_return <= 2'b00;
         coin_reject <= 1'b0;
         sold_out    <= 1'b0;
      end else begin
         state       <= state_next;
         credit      <= credit_next;
         timer       <= timer_next;
         purchase    <= purchase_next;
         vend_id     <= vend_id_next;
         cash_return <= cash_return_next;
         coin_reject <= coin_reject_next;
         sold_out    <= sold_out_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_FULL;
      end else begin
         for (int i = 0; i < N_PROD; i++) begin
            if (restock_en && restock_id == ID_W'(i))
               stock[i] <= STOCK_FULL;
            else if (dec_en && sel_id == ID_W'(i))
               stock[i] <= stock[i] - STOCK_W'(1);
         end
      end
   end

   assign present_state = state;

endmodule

// File: tb/tb_vm_param.sv
// Directed testbench for vm_param: each task drives one scenario and checks
// the registered outputs one time unit after the sampling edge.
module tb_vm_param;

   logic       clock;
   logic       reset;
   logic [1:0] cash_in;
   logic       sel_valid;
   logic [1:0] sel_id;
   logic       cancel;
   logic       restock;
   logic [1:0] restock_id;
   logic       purchase;
   logic [1:0] vend_id;
   logic [1:0] cash_return;
   logic       coin_reject;
   logic       sold_out;
   logic [5:0] credit;
   logic [1:0] present_state;

   int checks = 0;
   int errors = 0;

   vm_param dut (
      .clock(clock), .reset(reset), .cash_in(cash_in), .sel_valid(sel_valid),
      .sel_id(sel_id), .cancel(cancel), .restock(restock), .restock_id(restock_id),
      .purchase(purchase), .vend_id(vend_id), .cash_return(cash_return),
      .coin_reject(coin_reject), .sold_out(sold_out), .credit(credit),
      .present_state(present_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic coin(input logic [1:0] code);
      cash_in = code;
      step();
      cash_in = 2'b00;
   endtask

   task automatic select(input logic [1:0] id);
      sel_valid = 1'b1;
      sel_id    = id;
      step();
      sel_valid = 1'b0;
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      checks++; if (present_state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", present_state); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL reset_credit got %0d want 0", credit); end
      checks++; if ({purchase, cash_return, coin_reject, sold_out} !== 5'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b want 00000", {purchase, cash_return, coin_reject, sold_out}); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_vend();
      coin(2'b10);
      checks++; if (credit !== 6'd10) begin errors++; $display("[TB] FAIL vend_credit10 got %0d want 10", credit); end
      checks++; if (present_state !== 2'b01) begin errors++; $display("[TB] FAIL vend_collect got %0d want 1", present_state); end
      select(2'd2);
      checks++; if (purchase !== 1'b1) begin errors++; $display("[TB] FAIL vend_purchase got %0b want 1", purchase); end
      checks++; if (vend_id !== 2'd2) begin errors++; $display("[TB] FAIL vend_id got %0d want 2", vend_id); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL vend_credit0 got %0d want 0", credit); end
      checks++; if (present_state !== 2'b00) begin errors++; $display("[TB] FAIL vend_idle got %0d want 0", present_state); end
      step();
      checks++; if (purchase !== 1'b0) begin errors++; $display("[TB] FAIL vend_pulse_end got %0b want 0", purchase); end
      checks++; if (cash_return !== 2'b00) begin errors++; $display("[TB] FAIL vend_no_change got %0d want 0", cash_return); end
   endtask

   task automatic test_change();
      coin(2'b11);
      coin(2'b11);
      checks++; if (credit !== 6'd40) begin errors++; $display("[TB] FAIL chg_credit40 got %0d want 40", credit); end
      select(2'd0);
      checks++; if (purchase !== 1'b1) begin errors++; $display("[TB] FAIL chg_purchase got %0b want 1", purchase); end
      checks++; if (present_state !== 2'b10) begin errors++; $display("[TB] FAIL chg_state got %0d want 2", present_state); end
      checks++; if (credit !== 6'd30) begin errors++; $display("[TB] FAIL chg_credit30 got %0d want 30", credit); end
      step();
      checks++; if (cash_return !== 2'b11) begin errors++; $display("[TB] FAIL chg_coin20 got %0d want 3", cash_return); end
      checks++; if (credit !== 6'd10) begin errors++; $display("[TB] FAIL chg_credit10 got %0d want 10", credit); end
      checks++; if (present_state !== 2'b10) begin errors++; $display("[TB] FAIL chg_still got %0d want 2", present_state); end
      step();
      checks++; if (cash_return !== 2'b10) begin errors++; $display("[TB] FAIL chg_coin10 got %0d want 2", cash_return); end
      checks++; if (credit !== 6'd0) begin errors++; $display("[TB] FAIL chg_credit0 got %0d want 0", credit); end
      checks++; if (present_state !== 2'b00) begin errors++; $display("[TB] FAIL chg_idle got %0d want 0", present_state); end
      step();
      checks++; if (cash_return !== 2'b00) begin errors++; $display("[TB] FAIL chg_done got %0d want 0", cash_return); end
   endtask

   task automatic test_cancel();
      coin(2'b01);
      do_cancel();
      checks++; if (present_state !== 2'b10) begin errors++; $display("[TB] FAIL cancel_state got %0d want 2", present_state); end
      checks++; if (credit !== 6'd5) begin errors++; $display("[TB] FAIL cancel_credit got %0d want 5", credit); end
      checks++; if (cash_return !== 2'b00) begin errors++; $display("[TB] FAIL cancel_no_coin_yet got %0d want 0", cash_return); end
      step();
      checks++; if (cash_return !== 2'b01) begin errors++; $display("[TB] FAIL cancel_coin5 got %0d want 1", cash_return); end
      checks++; if (present_state !== 2'b00) begin errors++; $display("[TB] FAIL cancel_idle got %0d want 0", present_state); end
      step();
      checks++; if (cash_return !== 2'b00) begin errors++; $display("[TB] FAIL cancel_done got %0d want 0", cash_return); end
   endtask

   task automatic test_reject();
      coin(2'b11);
      coin(2'b11);
      coin(2'b01);
      checks++; if (coin_reject !== 1'b1) begin errors++; $display("[TB] FAIL rej_cap got %0b want 1", coin_reject); end
      checks++; if (credit !== 6'd40) begin errors++; $display("[TB] FAIL rej_credit got %0d want 40", credit); end
      step();
      checks++; if (coin_reject !== 1'b0) begin errors++; $display("[TB] FAIL rej_pulse_end got %0b want 0", coin_reject); end
      do_cancel();
      coin(2'b10);
      checks++; if (coin_reject !== 1'b1) begin errors++; $display("[TB] FAIL rej_change got %0b want 1", coin_reject); end
      checks++; if (credit !== 6'd20) begin errors++; $display("[TB] FAIL rej_change_credit got %0d want 20", credit); end
      checks++; if (cash_return !== 2'b11) begin errors++; $display("[TB] FAIL rej_change_coin got %0d want 3", cash_return); end
      step();
      checks++; if (credit !== 6'd0 || present_state !== 2'b00) begin errors++; $display("[TB] FAIL rej_finish got credit %0d state %0d want 0 0", credit, present_state); end
      step();
   endtask

   task automatic test_back_to_back();
      coin(2'b01);
      select(2'd3);
      checks++; if (purchase !== 1'b0 || credit !== 6'd5) begin errors++; $display("[TB] FAIL short_credit got purchase %0b credit %0d want 0 5", purchase, credit); end
      cash_in = 2'b01;
      select(2'd3);
      cash_in = 2'b00;
      checks++; if (purchase !== 1'b0 || coin_reject !== 1'b1) begin errors++; $display("[TB] FAIL sel_beats_coin got purchase %0b reject %0b want 0 1", purchase, coin_reject); end
      coin(2'b01);
      select(2'd3);
      checks++; if (purchase !== 1'b1 || vend_id !== 2'd3) begin errors++; $display("[TB] FAIL exact_price got purchase %0b id %0d want 1 3", purchase, vend_id); end
      checks++; if (present_state !== 2'b00) begin errors++; $display("[TB] FAIL exact_idle got %0d want 0", present_state); end
      step();
   endtask

   task automatic test_sold_out();
      for (int i = 0; i < 9; i++) begin
         coin(2'b10);
         select(2'd1);
         checks++; if (purchase !== 1'b1) begin errors++; $display("[TB] FAIL drain_%0d got %0b want 1", i, purchase); end
      end
      coin(2'b10);
      select(2'd1);
      checks++; if (sold_out !== 1'b1) begin errors++; $display("[TB] FAIL sold_out got %0b want 1", sold_out); end
      checks++; if (purchase !== 1'b0) begin errors++; $display("[TB] FAIL sold_out_nopurch got %0b want 0", purchase); end
      checks++; if (credit !== 6'd10 || present_state !== 2'b01) begin errors++; $display("[TB] FAIL sold_out_hold got credit %0d state %0d want 10 1", credit, present_state); end
      do_cancel();
      step();
      checks++; if (cash_return !== 2'b10 || present_state !== 2'b00) begin errors++; $display("[TB] FAIL sold_refund got coin %0d state %0d want 2 0", cash_return, present_state); end
      restock    = 1'b1;
      restock_id = 2'd1;
      step();
      restock    = 1'b0;
      coin(2'b10);
      select(2'd1);
      checks++; if (purchase !== 1'b1 || vend_id !== 2'd1) begin errors++; $display("[TB] FAIL restock got purchase %0b id %0d want 1 1", purchase, vend_id); end
      step();
   endtask

   task automatic test_timeout();
      coin(2'b01);
      repeat (14) step();
      checks++; if (present_state !== 2'b01) begin errors++; $display("[TB] FAIL tmo_early got %0d want 1", present_state); end
      step();
      checks++; if (present_state !== 2'b10) begin errors++; $display("[TB] FAIL tmo_change got %0d want 2", present_state); end
      step();
      checks++; if (cash_return !== 2'b01 || present_state !== 2'b00) begin errors++; $display("[TB] FAIL tmo_refund got coin %0d state %0d want 1 0", cash_return, present_state); end
      step();
   endtask

   task automatic test_reset_mid_change();
      coin(2'b11);
      coin(2'b10);
      do_cancel();
      step();
      checks++; if (cash_return !== 2'b11 || credit !== 6'd10) begin errors++; $display("[TB] FAIL rmc_first got coin %0d credit %0d want 3 10", cash_return, credit); end
      #2 reset = 1'b1;
      #1;
      checks++; if (cash_return !== 2'b00 || credit !== 6'd0 || present_state !== 2'b00) begin errors++; $display("[TB] FAIL rmc_async got coin %0d credit %0d state %0d want 0 0 0", cash_return, credit, present_state); end
      #2 reset = 1'b0;
      step();
      checks++; if (cash_return !== 2'b00 || present_state !== 2'b00) begin errors++; $display("[TB] FAIL rmc_after got coin %0d state %0d want 0 0", cash_return, present_state); end
   endtask

   initial begin
      cash_in    = 2'b00;
      sel_valid  = 1'b0;
      sel_id     = 2'd0;
      cancel     = 1'b0;
      restock    = 1'b0;
      restock_id = 2'd0;
      reset      = 1'b0;
      test_reset();
      test_vend();
      test_change();
      test_cancel();
      test_reject();
      test_back_to_back();
      test_sold_out();
      test_timeout();
      test_reset_mid_change();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vm_param.md
Name: vm_param

Overview:
- Parametrised successor vending-machine controller. Supports N_PROD products at one shared PRICE, per-product stock counters and a multi-coin credit accumulator.
- Change is returned one coin per cycle using greedy denominations. Also supports cancel, inactivity timeout, coin rejection above a credit cap, and restocking.
- Sits between the coin-acceptor front end and the dispenser/coin-return actuators.

Parameters:
- PRICE, 10, product price in taka; must be a multiple of 5 and at least 5.
- MAX_CREDIT, 40, credit cap in taka; must be a multiple of 5 and at least PRICE.
- CREDIT_W, 6, credit register width; 2^CREDIT_W must exceed MAX_CREDIT+20.
- N_PROD, 4, number of products.
- ID_W, 2, product-id width; 2^ID_W must be at least N_PROD.
- STOCK_MAX, 9, stock count after restock.
- STOCK_W, 4, per-product stock width.
- TIMEOUT, 15, number of idle COLLECT cycles before automatic refund; must be at least 1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- cash_in  in  2  coin this cycle: 00 none, 01 5tk, 10 10tk, 11 20tk
- sel_valid  in  1  product selection strobe
- sel_id  in  ID_W  selected product
- cancel  in  1  refund request
- restock  in  1  restock strobe
- restock_id  in  ID_W  product to restock
- purchase  out  1  one-cycle vend pulse
- vend_id  out  ID_W  product vended; valid while purchase=1
- cash_return  out  2  change coin this cycle; same encoding as cash_in (00 = none)
- coin_reject  out  1  one-cycle pulse: the coin sampled this edge was not credited
- sold_out  out  1  one-cycle pulse: the selected product has zero stock
- credit  out  CREDIT_W  current credit in taka
- present_state  out  2  00 IDLE, 01 COLLECT, 10 CHANGE

Behaviour:
- All outputs are registered.
- Pulse outputs (purchase, coin_reject, sold_out) and cash_return are high in the cycle following the sampling edge, and default to 0 otherwise.
- Reset (async) sets state to IDLE and clears credit, the timeout counter, purchase, vend_id, cash_return, coin_reject and sold_out to 0. Every stock counter is set to STOCK_MAX.
- Reset asserted mid-vend or mid-change discards credit. No change is returned.
- Coin value v is 5, 10 or 20.
- A coin is accepted when the state is IDLE or COLLECT, credit+v is at most MAX_CREDIT, and neither sel_valid nor cancel is high in the same cycle.
  - Accepted: credit += v, state becomes COLLECT, timeout counter clears.
  - Otherwise (any nonzero cash_in): coin_reject=1 and credit is unchanged. This includes every coin arriving in CHANGE.
- IDLE:
  - restock=1 sets stock[restock_id] to STOCK_MAX.
  - restock is ignored in any other state.
  - restock_id >= N_PROD is ignored.
  - sel_valid and cancel are ignored in IDLE.
- COLLECT, evaluated with priority cancel > sel_valid > coin > timeout:
  - cancel: state becomes CHANGE; credit is unchanged.
  - sel_valid with sel_id >= N_PROD: ignored. This counts as activity, so the timeout counter clears.
  - sel_valid with stock[sel_id]==0: sold_out=1; stay in COLLECT; timeout counter clears.
  - sel_valid with credit < PRICE: no action; stay in COLLECT; timeout counter clears.
  - sel_valid with credit >= PRICE: purchase=1, vend_id=sel_id, stock[sel_id] -= 1, credit -= PRICE. Next state is IDLE if the new credit is 0, else CHANGE.
  - No event: the timeout counter increments. When it reaches TIMEOUT, state becomes CHANGE.
- CHANGE: each cycle emits one coin chosen greedily, then credit -= that coin:
  - 20 if credit >= 20,
  - else 10 if credit >= 10,
  - else 5.
  - When credit reaches 0 on that edge, state becomes IDLE. The last coin is still shown on cash_return in the following cycle.
  - Change duration is deterministic. Example: 35tk takes 3 cycles (20, 10, 5).
- Stock never underflows; the sold_out check guarantees it.
- Credit never exceeds MAX_CREDIT.

Test Plan:
- Reset, then 10tk, then sel_valid id 2 → purchase=1 and vend_id=2 the next cycle; stock[2]=8; credit=0; state returns to IDLE with no change.
- 20tk then 20tk (credit 40), then sel id 0 → purchase=1; state CHANGE; cash_return sequence is 20, 10 on consecutive cycles; credit 0; state IDLE.
- 5tk, then cancel → state CHANGE; cash_return=01 for one cycle; then IDLE.
- Credit 40, then insert 5tk → coin_reject=1 and credit stays 40. In CHANGE, insert 10tk → coin_reject=1.
- Exhaust stock[1] with 9 vends, then 10tk and sel id 1 → sold_out=1, purchase=0, credit stays 10. Then restock id 1 in IDLE after the refund → stock[1]=9.
- 5tk, then no input for 15 cycles → state becomes CHANGE at the timeout; cash_return=01; IDLE afterwards. Also assert reset during CHANGE with credit 30 → all outputs are 0 immediately and credit=0.
